// File: rtl/fifo_pkg.sv
// Shared definitions for the flexible FIFO: read-mode selectors and pointer sizing.
package fifo_pkg;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // One extra pointer bit separates the full and empty cases when the low bits match.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read. Contents are never reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through read, fill count,
// programmable almost flags, sticky overflow/underflow and synchronous clear.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1,
  localparam int PW        = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_L = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AE_L = PW'(AEMPTY_LVL);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  // Flags depend only on registered pointers, never on this cycle's inputs.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = ovf_q | (wr_en & full);
    udf_d    = udf_q | (rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (!arst_n || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = head;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!arst_n || clr) dout_q <= '0;
      else if (pop)       dout_q <= head;
    end
    assign data_out = dout_q;
  end
endmodule

// File: tb/tb_fifo_flex.sv
// Drives a standard-read and a FWFT instance with identical stimulus and checks both
// against a queue-based reference model.
module tb_fifo_flex;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, clr, wr_en, rd_en;
  logic [7:0] data_in;
  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt0, cnt1;

  fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_LVL(6), .AEMPTY_LVL(1)) d_std (
    .clk(clk), .arst_n(arst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0));

  fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AFULL_LVL(6), .AEMPTY_LVL(1)) d_fwft (
    .clk(clk), .arst_n(arst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1));

  int nchk = 0;
  int nerr = 0;

  // Reference model
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_udf;
  int         pops_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".cnt0"},  32'(cnt0),   32'(n));
    chk({tag, ".full0"}, 32'(full0),  32'(n == 8));
    chk({tag, ".emp0"},  32'(empty0), 32'(n == 0));
    chk({tag, ".af0"},   32'(af0),    32'(n >= 6));
    chk({tag, ".ae0"},   32'(ae0),    32'(n <= 1));
    chk({tag, ".ovf0"},  32'(ovf0),   32'(m_ovf));
    chk({tag, ".udf0"},  32'(udf0),   32'(m_udf));
    chk({tag, ".dout0"}, 32'(dout0),  32'(m_dout));
    chk({tag, ".cnt1"},  32'(cnt1),   32'(n));
    chk({tag, ".emp1"},  32'(empty1), 32'(n == 0));
    chk({tag, ".full1"}, 32'(full1),  32'(n == 8));
    chk({tag, ".af1"},   32'(af1),    32'(n >= 6));
    chk({tag, ".ae1"},   32'(ae1),    32'(n <= 1));
    chk({tag, ".ovf1"},  32'(ovf1),   32'(m_ovf));
    chk({tag, ".udf1"},  32'(udf1),   32'(m_udf));
    if (n > 0) chk({tag, ".dout1"}, 32'(dout1), 32'(q[0]));
  endtask

  // One clock: apply inputs, let the edge happen, update model, check at the falling edge.
  task automatic cyc(input string tag, input bit w, input bit r, input logic [7:0] d,
                     input bit c = 1'b0, input bit rst = 1'b0);
    bit pre_full, pre_empty;
    arst_n = ~rst; clr = c; wr_en = w; rd_en = r; data_in = d;
    @(posedge clk);
    pre_full  = (q.size() == 8);
    pre_empty = (q.size() == 0);
    if (rst || c) begin
      q.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (r && pre_empty) m_udf = 1'b1;
      if (w && pre_full)  m_ovf = 1'b1;
      if (r && !pre_empty) begin m_dout = q.pop_front(); pops_total++; end
      if (w && !pre_full)  q.push_back(d);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    arst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; pops_total = 0;
    @(negedge clk);
    cyc("reset", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    cyc("reset2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill past full: words 8 and 9 dropped, overflow sets
    for (int i = 0; i < 10; i++) cyc("fill", 1'b1, 1'b0, 8'(i));
    // Drain plus one extra pop: underflow, data_out holds 7
    for (int i = 0; i < 9; i++) cyc("drain", 1'b0, 1'b1, 8'h00);

    // Threshold walk
    cyc("clr_a", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) cyc("thr_up", 1'b1, 1'b0, 8'(8'h40 + i));
    cyc("thr_dn", 1'b0, 1'b1, 8'h00);

    // Simultaneous push+pop at count 3
    cyc("clr_b", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc("to3", 1'b1, 1'b0, 8'(8'h10 + i));
    cyc("pp3", 1'b1, 1'b1, 8'h13);
    cyc("pp3b", 1'b1, 1'b1, 8'h14);
    // Push+pop on full: pop accepted, push rejected
    for (int i = 0; i < 5; i++) cyc("tofull", 1'b1, 1'b0, 8'(8'h20 + i));
    cyc("ppfull", 1'b1, 1'b1, 8'hEE);
    // Push+pop on empty: push accepted, pop rejected
    cyc("clr_c", 1'b0, 1'b0, 8'h00, 1'b1);
    cyc("ppempty", 1'b1, 1'b1, 8'h77);
    cyc("ppempty_rd", 1'b0, 1'b1, 8'h00);

    // Random traffic; long enough that pointers wrap several times
    cyc("clr_d", 1'b0, 1'b0, 8'h00, 1'b1);
    pops_total = 0;
    for (int i = 0; i < 200; i++)
      cyc("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
          8'($urandom_range(0, 255)));
    chk("wrap_twice", 32'(pops_total >= 32), 32'd1);

    // Fall-through of a single word into an empty FIFO, no rd_en
    cyc("clr_e", 1'b0, 1'b0, 8'h00, 1'b1);
    cyc("a5_push", 1'b1, 1'b0, 8'hA5);
    chk("a5_fwft", 32'(dout1), 32'hA5);
    cyc("a5_hold", 1'b0, 1'b0, 8'h00);

    // clr with count=5 and overflow set
    for (int i = 0; i < 8; i++) cyc("ovf_fill", 1'b1, 1'b0, 8'(8'hB0 + i));
    for (int i = 0; i < 3; i++) cyc("ovf_pop", 1'b0, 1'b1, 8'h00);
    chk("pre_clr_cnt", 32'(cnt1), 32'd5);
    chk("pre_clr_ovf", 32'(ovf1), 32'd1);
    cyc("clr_f", 1'b1, 1'b1, 8'h55, 1'b1);
    cyc("post_clr", 1'b0, 1'b0, 8'h00);

    // Reset beats clr and traffic mid-stream
    for (int i = 0; i < 4; i++) cyc("pre_rst", 1'b1, 1'b0, 8'(i));
    cyc("rst_mid", 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
